i2s_capture_multi: RTL and testbench
====================================

# i2s_capture_multi

Parametrised multi-line I2S receiver that replaces the single-line 24-bit capture stage in the mic front end. It samples NUM_LINES serial data lines that share one SCK/WS pair, with two channels per line. It captures SAMPLE_W MSB-first bits per slot and sign-extends each word to OUT_W. Words are tagged with a channel index and queued in an internal FIFO behind a valid/ready stream that feeds the ping-pong RAM writer.

## Interface
- SAMPLE_W, 24: captured bits per slot, MSB-first; 1..SLOT_W.
- SLOT_W, 32: SCK periods per WS half-frame.
- NUM_LINES, 2: number of SD inputs; channel count is CH = 2*NUM_LINES.
- OUT_W, 32: output word width; must be ≥ SAMPLE_W; samples are sign-extended.
- FIFO_DEPTH, 16: output FIFO entries; power of 2, ≥ 2.
- clk_i, in, 1: system clock.
- rst_ni, in, 1: asynchronous active-low reset.
- sck_i, in, 1: I2S bit clock, sampled in the clk_i domain.
- ws_i, in, 1: word select; 0 = left, 1 = right.
- sd_i, in, NUM_LINES: serial data, one bit per line.
- enable_i, in, 1: capture enable.
- chan_mask_i, in, CH: bit c set = channel c is pushed to the FIFO.
- clear_i, in, 1: synchronous pulse that clears overflow_o and drop_count_o.
- m_data_o, out, OUT_W: sign-extended sample.
- m_chan_o, out, max(1,$clog2(CH)): channel index = 2*line + ws.
- m_valid_o, out, 1: output word valid.
- m_ready_i, in, 1: consumer ready.
- fifo_count_o, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- overflow_o, out, 1: sticky flag, set on any dropped word.
- drop_count_o, out, 16: count of dropped words, saturating at 0xFFFF.

## Operation
- **Input synchronisation:** sck_i, ws_i and sd_i all pass through identical 2-flop synchronisers, which keeps them aligned. A rising SCK edge is detected as sck_s & ~sck_q (1 clk). All capture actions happen only in rising-edge cycles.
- **Bit counter:**
  - ws_q holds WS from the previous rising edge.
  - If ws_s != ws_q at a rising edge: bit_cnt := 0, and the bit sampled on that edge is discarded (I2S 1-bit delay).
  - Otherwise bit_cnt increments, saturating at SLOT_W.
  - At bit_cnt 1..SAMPLE_W, each line's shift register shifts in its sd bit.
  - When bit_cnt reaches SAMPLE_W, the word is complete for channel ws_s on all lines simultaneously.
- **Capture FSM, SYNC:**
  - Entered on reset or whenever enable_i = 0.
  - Leaves to RUN on a rising edge where enable_i = 1 and WS falls (1→0), i.e. start of a left slot.
  - No words are produced in SYNC.
- **Capture FSM, RUN:**
  - Word completion loads all NUM_LINES words into the holding bank, together with the ws of that slot.
  - If enable_i drops, the FSM returns to SYNC immediately and the partial word is discarded.
  - FIFO contents are preserved.
- **Serializer FSM, IDLE:** on a bank load, go to PUSH with line index i = 0.
- **Serializer FSM, PUSH:**
  - Each clk, line i is presented with channel c = 2*i + ws.
  - If chan_mask_i[c] = 0, the word is skipped (not counted as a drop).
  - Otherwise the word is written to the FIFO if there is space.
  - Then i increments; after i = NUM_LINES-1 the FSM returns to IDLE.
  - If a bank load arrives while in PUSH, the unpushed old-bank words with their mask bit set are counted as drops, and pushing restarts at i = 0 on the new bank.
- **Drops:**
  - A push is accepted when FIFO count < FIFO_DEPTH, or when FIFO is full and a pop happens the same cycle.
  - Otherwise the word is dropped: overflow_o := 1 and drop_count_o is incremented with saturation.
  - clear_i takes priority over a simultaneous drop; the counter reads 0 after the clear.
- **FIFO:**
  - First-word-fall-through; the pop condition is m_valid_o & m_ready_i.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an explicit counter.
  - A simultaneous push and pop leaves the count unchanged.
- **Width rule:** m_data_o = {{(OUT_W-SAMPLE_W){w[SAMPLE_W-1]}}, w}.

## Timing
- **Reset values:** m_valid_o = 0, m_data_o = 0, m_chan_o = 0, fifo_count_o = 0, overflow_o = 0, drop_count_o = 0. Both FSMs reset to SYNC/IDLE.
- **Latency:**
  - Raw pins to detected edge: 3 clk.
  - Completing rising-edge cycle to bank load: +1 clk.
  - Bank load to first FIFO write: +1 clk.
  - FIFO write to m_valid_o high: +1 clk.
- **Throughput:** one FIFO write per clk, so NUM_LINES clk are needed per bank. This is required to be ≤ (SLOT_W-SAMPLE_W+1) SCK periods, which is always true at default parameters.
- **Output stability:** while m_valid_o = 1 and m_ready_i = 0, m_data_o and m_chan_o hold stable.
- **Async reset mid-frame:** all outputs clear immediately, with no partial word after release. Capture restarts at the next WS falling edge.

## Test plan
- **Basic stereo capture:** default parameters, line 0 L = 0x123456, R = 0x800001, line 1 L = 0x7FFFFF, R = 0x000000, mask all ones, m_ready_i = 1.
  - Required stream per frame: (0,0x00123456), (2,0x007FFFFF), (1,0xFF800001), (3,0x00000000).
- **Enable mid-right-slot:** assert enable_i in the middle of a right slot → no word until the next left slot completes; the first word out has chan 0.
- **Channel mask:** chan_mask_i = 4'b0101 → only channels 0 and 2 appear; drop_count_o stays 0.
- **Overflow:** m_ready_i = 0 for 6 frames.
  - FIFO holds 16 words; fifo_count_o = 16.
  - 8 further words are dropped: drop_count_o = 8, overflow_o = 1.
  - Releasing m_ready_i drains the 16 words in order.
  - A clear_i pulse then gives 0/0.
- **Full with same-cycle pop:** FIFO full with a pop in the same cycle as a push → push accepted, count stays 16, no drop.
- **Reset mid-frame:** assert rst_ni low at bit 10 of a left slot → outputs are 0 during reset; after release the first word out is from the next complete left slot.

Source files
------------

// File: rtl/i2s_capture_multi.sv
// Multi-line I2S receiver: NUM_LINES serial lines share one SCK/WS pair. Words are sign-extended,
// tagged with channel 2*line+ws, and queued in a FWFT FIFO behind a valid/ready stream.

module i2s_cap_lane #(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                shift_en,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] word_nxt
);
  logic [SAMPLE_W-1:0] sh;

  // word_nxt already contains the bit arriving this edge, so the completing cycle can use it directly
  assign word_nxt = (sh << 1) | SAMPLE_W'(sd);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)       sh <= '0;
    else if (shift_en) sh <= word_nxt;
endmodule

module i2s_capture_multi #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_LINES  = 2,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int CH  = 2 * NUM_LINES,
  localparam int CHW = (CH > 2) ? $clog2(CH) : 1,
  localparam int AW  = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sck_i,
  input  logic                 ws_i,
  input  logic [NUM_LINES-1:0] sd_i,
  input  logic                 enable_i,
  input  logic [CH-1:0]        chan_mask_i,
  input  logic                 clear_i,
  output logic [OUT_W-1:0]     m_data_o,
  output logic [CHW-1:0]       m_chan_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [AW:0]          fifo_count_o,
  output logic                 overflow_o,
  output logic [15:0]          drop_count_o
);
  localparam int IW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int BCW = $clog2(SLOT_W + 1);

  localparam logic C_SYNC = 1'b0, C_RUN  = 1'b1;
  localparam logic S_IDLE = 1'b0, S_PUSH = 1'b1;

  typedef struct packed {
    logic [CHW-1:0]      chan;
    logic [SAMPLE_W-1:0] word;
  } ent_t;

  // all three inputs see the same flop depth so WS and SD stay aligned with SCK
  logic sck_m, sck_s, sck_q, ws_m, ws_s;
  logic [NUM_LINES-1:0] sd_m, sd_s;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      {sck_m, sck_s, sck_q, ws_m, ws_s} <= '0;
      sd_m <= '0;
      sd_s <= '0;
    end else begin
      {sck_m, sck_s, sck_q} <= {sck_i, sck_m, sck_s};
      {ws_m, ws_s}          <= {ws_i, ws_m};
      sd_m <= sd_i;
      sd_s <= sd_m;
    end

  logic           rise, ws_q, ws_chg, shift_en, done;
  logic [BCW-1:0] bit_cnt, cnt_nxt;
  logic           cap_st;
  logic [NUM_LINES-1:0][SAMPLE_W-1:0] lane_nxt;

  assign rise     = sck_s & ~sck_q;
  assign ws_chg   = ws_s ^ ws_q;
  assign cnt_nxt  = (bit_cnt == BCW'(SLOT_W)) ? bit_cnt : bit_cnt + 1'b1;
  assign shift_en = rise & ~ws_chg & (cnt_nxt <= BCW'(SAMPLE_W));
  assign done     = rise & ~ws_chg & (cnt_nxt == BCW'(SAMPLE_W)) & (cap_st == C_RUN) & enable_i;

  // the bit sampled on the WS-change edge is the previous slot's LSB and is dropped
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bit_cnt <= '0;
      ws_q    <= 1'b0;
    end else if (rise) begin
      ws_q    <= ws_s;
      bit_cnt <= ws_chg ? '0 : cnt_nxt;
    end

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_lane
    i2s_cap_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .shift_en (shift_en),
      .sd       (sd_s[l]),
      .word_nxt (lane_nxt[l])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)                                          cap_st <= C_SYNC;
    else if (!enable_i)                                   cap_st <= C_SYNC;
    else if (cap_st == C_SYNC && rise && ws_q && !ws_s)   cap_st <= C_RUN;

  logic [NUM_LINES-1:0][SAMPLE_W-1:0] cap_word, bank;
  logic cap_ws, cap_ld, bank_ws, ser_st;
  logic [IW-1:0] idx;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cap_ld   <= 1'b0;
      cap_ws   <= 1'b0;
      cap_word <= '0;
    end else begin
      cap_ld <= done;
      if (done) begin
        cap_word <= lane_nxt;
        cap_ws   <= ws_s;
      end
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ser_st  <= S_IDLE;
      idx     <= '0;
      bank    <= '0;
      bank_ws <= 1'b0;
    end else if (cap_ld) begin
      ser_st  <= S_PUSH;
      idx     <= '0;
      bank    <= cap_word;
      bank_ws <= cap_ws;
    end else if (ser_st == S_PUSH) begin
      if (idx == IW'(NUM_LINES - 1)) ser_st <= S_IDLE;
      else                           idx    <= idx + 1'b1;
    end

  logic [CHW-1:0] cur_c;
  logic push_req, push, pop, full, drop_one, preempt;
  logic [15:0] pre_drops, drop_inc;
  logic [16:0] drop_sum;

  assign cur_c    = CHW'({idx, bank_ws});
  assign preempt  = (ser_st == S_PUSH) & cap_ld;
  assign push_req = (ser_st == S_PUSH) & ~cap_ld & chan_mask_i[cur_c];
  assign full     = (fifo_count_o == (AW+1)'(FIFO_DEPTH));
  assign pop      = m_valid_o & m_ready_i;
  assign push     = push_req & (~full | pop);
  assign drop_one = push_req & ~push;

  // a new bank arriving mid-burst forfeits every still-unsent enabled word of the old bank
  always_comb begin
    pre_drops = '0;
    for (int l = 0; l < NUM_LINES; l++)
      if (l >= int'(idx) && chan_mask_i[CHW'(2*l + int'(bank_ws))])
        pre_drops = pre_drops + 16'd1;
  end

  assign drop_inc = preempt ? pre_drops : {15'd0, drop_one};
  assign drop_sum = {1'b0, drop_count_o} + {1'b0, drop_inc};

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (clear_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (drop_inc != '0) begin
      overflow_o   <= 1'b1;
      drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

  ent_t mem [FIFO_DEPTH];
  ent_t head;
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= '{chan: cur_c, word: bank[idx]};

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
        2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
        default: fifo_count_o <= fifo_count_o;
      endcase
    end

  // storage is not reset, so the outputs are forced to zero while empty
  assign head      = mem[rd_ptr];
  assign m_valid_o = (fifo_count_o != '0);
  assign m_data_o  = m_valid_o ? OUT_W'($signed(head.word)) : '0;
  assign m_chan_o  = m_valid_o ? head.chan : '0;
endmodule

// File: tb/tb_i2s_capture_multi.sv
// Randomized bench for i2s_capture_multi: drives whole I2S frames and checks the word stream,
// occupancy and drop accounting against a frame-level queue model.

module tb_i2s_capture_multi;
  localparam int NL = 2, SW = 24, SLOT = 32, OW = 32, DEPTH = 16, CH = 4;

  logic clk = 1'b0;
  logic rst_ni, sck_i, ws_i, enable_i, clear_i, m_valid_o, m_ready_i, overflow_o;
  logic [NL-1:0]  sd_i;
  logic [CH-1:0]  chan_mask_i;
  logic [OW-1:0]  m_data_o;
  logic [1:0]     m_chan_o;
  logic [4:0]     fifo_count_o;
  logic [15:0]    drop_count_o;

  always #5 clk = ~clk;

  i2s_capture_multi #(
    .SAMPLE_W(SW), .SLOT_W(SLOT), .NUM_LINES(NL), .OUT_W(OW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .enable_i(enable_i), .chan_mask_i(chan_mask_i), .clear_i(clear_i),
    .m_data_o(m_data_o), .m_chan_o(m_chan_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } word_t;

  word_t exp_q[$];
  word_t mon_e;
  int total = 0, bad = 0, exp_drops = 0;
  bit hold = 1'b0, rnd_rdy = 1'b0;
  logic [NL-1:0][SW-1:0] lw, rw;
  event rise24;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] sext(input logic [SW-1:0] w);
    return {{(OW-SW){w[SW-1]}}, w};
  endfunction

  // left words of every line first, then right; hold models a stalled consumer
  task automatic model_frame(input logic [NL-1:0][SW-1:0] l_w, input logic [NL-1:0][SW-1:0] r_w);
    word_t e;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < NL; l++)
        if (chan_mask_i[2*l+s]) begin
          if (hold && exp_q.size() >= DEPTH) exp_drops++;
          else begin
            e.chan = 2'(2*l + s);
            e.data = sext(s ? r_w[l] : l_w[l]);
            exp_q.push_back(e);
          end
        end
  endtask

  task automatic rnd_words();
    for (int l = 0; l < NL; l++) begin
      lw[l] = SW'($urandom);
      rw[l] = SW'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rnd_rdy) m_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sck_period(input logic ws, input logic [NL-1:0] sd, input bit mark);
    step();
    sck_i = 1'b0; ws_i = ws; sd_i = sd;
    repeat (4) step();
    sck_i = 1'b1;
    if (mark) -> rise24;
    repeat (3) step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sck_period(1'b1, NL'($urandom), 1'b0);
  endtask

  task automatic do_reset_mid();
    step();
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_valid", m_valid_o, 0);
    chk("rst_mid_data", m_data_o, 0);
    chk("rst_mid_chan", m_chan_o, 0);
    chk("rst_mid_count", fifo_count_o, 0);
    chk("rst_mid_ovf", overflow_o, 0);
    chk("rst_mid_drops", drop_count_o, 0);
    exp_q.delete();
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  // period p=0 of a slot carries the previous LSB (junk here); p=1..SW carry MSB..LSB
  task automatic send_frame(input logic [NL-1:0][SW-1:0] l_w, input logic [NL-1:0][SW-1:0] r_w,
                            input int en_at, input int rst_at, input bit pulse);
    logic [NL-1:0][SW-1:0] cur;
    logic [NL-1:0] sd;
    int p;
    for (int k = 0; k < 2*SLOT; k++) begin
      p   = k % SLOT;
      cur = (k >= SLOT) ? r_w : l_w;
      for (int l = 0; l < NL; l++)
        sd[l] = (p >= 1 && p <= SW) ? cur[l][SW-p] : 1'($urandom);
      if (k == en_at)  enable_i = 1'b1;
      if (k == rst_at) do_reset_mid();
      sck_period(k >= SLOT, sd, pulse && (k == SW));
    end
  endtask

  task automatic wait_drain();
    rnd_rdy   = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_count", fifo_count_o, 0);
  endtask

  always @(negedge clk)
    if (rst_ni) begin
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_word", m_valid_o, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("chan", m_chan_o, mon_e.chan);
          chk("data", m_data_o, mon_e.data);
        end
      end else if (m_valid_o && exp_q.size() != 0)
        chk("head_hold", m_data_o, exp_q[0].data);
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; sck_i = 1'b0; ws_i = 1'b1; sd_i = '0; enable_i = 1'b0;
    clear_i = 1'b0; chan_mask_i = '1; m_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_chan", m_chan_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drops", drop_count_o, 0);
    rst_ni = 1'b1;
    enable_i = 1'b1;
    idle(4);

    // fixed stereo pattern
    lw = {24'h7FFFFF, 24'h123456};
    rw = {24'h000000, 24'h800001};
    repeat (2) begin
      model_frame(lw, rw);
      send_frame(lw, rw, -1, -1, 1'b0);
    end
    wait_drain();

    // random words, masks and back-pressure
    rnd_rdy = 1'b1;
    repeat (6) begin
      rnd_words();
      chan_mask_i = CH'($urandom);
      model_frame(lw, rw);
      send_frame(lw, rw, -1, -1, 1'b0);
    end
    wait_drain();

    // masked channels are skipped, not dropped
    chan_mask_i = 4'b0101;
    repeat (2) begin
      rnd_words();
      model_frame(lw, rw);
      send_frame(lw, rw, -1, -1, 1'b0);
    end
    wait_drain();
    chk("mask_drops", drop_count_o, 0);
    chk("mask_ovf", overflow_o, 0);

    // enable raised mid right slot: that frame yields nothing
    chan_mask_i = '1;
    enable_i = 1'b0;
    idle(2);
    rnd_words();
    send_frame(lw, rw, 48, -1, 1'b0);
    rnd_words();
    model_frame(lw, rw);
    send_frame(lw, rw, -1, -1, 1'b0);
    wait_drain();

    // overflow with a stalled consumer
    m_ready_i = 1'b0;
    hold = 1'b1;
    exp_drops = 0;
    repeat (6) begin
      rnd_words();
      model_frame(lw, rw);
      send_frame(lw, rw, -1, -1, 1'b0);
    end
    hold = 1'b0;
    repeat (4) step();
    chk("ovf_count", fifo_count_o, DEPTH);
    chk("ovf_drops", drop_count_o, exp_drops);
    chk("ovf_flag", overflow_o, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();
    chk("clr_drops", drop_count_o, 0);
    chk("clr_flag", overflow_o, 0);
    chk("clr_count", fifo_count_o, DEPTH);

    // full FIFO, consumer ready exactly during the two left-word pushes
    chan_mask_i = 4'b0101;
    rnd_words();
    model_frame(lw, rw);
    fork
      begin
        @(rise24);
        repeat (4) @(posedge clk);
        #1 m_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 m_ready_i = 1'b0;
      end
      send_frame(lw, rw, -1, -1, 1'b1);
    join
    chk("fullpop_count", fifo_count_o, DEPTH);
    chk("fullpop_drops", drop_count_o, 0);
    chk("fullpop_flag", overflow_o, 0);
    wait_drain();

    // async reset in the middle of a left slot with words pending
    chan_mask_i = '1;
    m_ready_i = 1'b0;
    rnd_words();
    model_frame(lw, rw);
    send_frame(lw, rw, -1, -1, 1'b0);
    rnd_words();
    send_frame(lw, rw, -1, 10, 1'b0);
    m_ready_i = 1'b1;
    rnd_words();
    model_frame(lw, rw);
    send_frame(lw, rw, -1, -1, 1'b0);
    wait_drain();
    chk("final_drops", drop_count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
